// File: rtl/datapath_rr_arbiter.sv
// Round-robin arbiter granting one of NOF_REQ requesters a bounded burst on a shared datapath.
// Optional feature: define ARB_LOCK_EN to add req_lock_i, which suspends the burst limit for the owner.
module datapath_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NOF_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NOF_REQ-1:0]         req_valid_i,
  input  logic [NOF_REQ*WIDTH-1:0]   req_data_i,
`ifdef ARB_LOCK_EN
  input  logic [NOF_REQ-1:0]         req_lock_i,
`endif
  output logic [NOF_REQ-1:0]         req_ready_o,
  input  logic                       dp_ready_i,
  output logic                       dp_enable_o,
  output logic [WIDTH-1:0]           dp_data_o,
  output logic [NOF_REQ-1:0]         grant_o,
  output logic [$clog2(NOF_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NOF_REQ);
  localparam int CW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;
  localparam logic [IDW-1:0] LAST_REQ  = IDW'(NOF_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] cand;
  int             idx;

  logic           owner_vld;
  logic           xfer;
  logic           limit_on;
  logic           limit_hit;

  // Scan from the farthest candidate to the nearest so the nearest one after last_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    idx      = 0;
    for (int i = NOF_REQ; i >= 1; i--) begin
      idx = int'(last_q) + i;
      if (idx >= NOF_REQ) begin
        idx = idx - NOF_REQ;
      end
      cand = IDW'(idx);
      if (req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
`ifdef ARB_LOCK_EN
    limit_on = (MAX_BURST > 0) && !req_lock_i[owner_q];
`else
    limit_on = (MAX_BURST > 0);
`endif
  end

  assign owner_vld = req_valid_i[owner_q];
  assign xfer      = (state_q == GRANT) && owner_vld && dp_ready_i;
  // Counter saturates while locked, so dropping the lock releases at the very next transfer.
  assign limit_hit = limit_on && (cnt_q >= LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    dp_enable_o = 1'b0;
    dp_data_o   = '0;
    req_ready_o = '0;
    grant_o     = '0;
    grant_id_o  = '0;
    busy_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_id;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        busy_o               = 1'b1;
        grant_o[owner_q]     = 1'b1;
        grant_id_o           = owner_q;
        dp_enable_o          = owner_vld;
        dp_data_o            = owner_vld ? req_data_i[owner_q*WIDTH +: WIDTH] : '0;
        req_ready_o[owner_q] = dp_ready_i;

        if (xfer && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end

        if (!owner_vld || (xfer && limit_hit)) begin
          state_d = IDLE;
          last_d  = owner_q;
          owner_d = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_REQ;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_datapath_rr_arbiter.sv
// Directed bench for datapath_rr_arbiter (WIDTH=8, NOF_REQ=4, MAX_BURST=4).
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_datapath_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NOF_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic [NOF_REQ-1:0]       req_valid_i = '0;
  logic [NOF_REQ*WIDTH-1:0] req_data_i;
  logic [NOF_REQ-1:0]       req_lock_i = '0;
  logic [NOF_REQ-1:0]       req_ready_o;
  logic                     dp_ready_i = 1'b1;
  logic                     dp_enable_o;
  logic [WIDTH-1:0]         dp_data_o;
  logic [NOF_REQ-1:0]       grant_o;
  logic [1:0]               grant_id_o;
  logic                     busy_o;

  int vectors = 0;
  int errors  = 0;

  datapath_rr_arbiter #(
    .WIDTH    (WIDTH),
    .NOF_REQ  (NOF_REQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
`ifdef ARB_LOCK_EN
    .req_lock_i (req_lock_i),
`endif
    .req_ready_o(req_ready_o),
    .dp_ready_i (dp_ready_i),
    .dp_enable_o(dp_enable_o),
    .dp_data_o  (dp_data_o),
    .grant_o    (grant_o),
    .grant_id_o (grant_id_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Requester r always offers 8'hA0 + 8'h11*r.
  assign req_data_i = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  // {busy, grant, grant_id, enable, data, ready}
  function automatic logic [19:0] obs();
    return {busy_o, grant_o, grant_id_o, dp_enable_o, dp_data_o, req_ready_o};
  endfunction

  function automatic logic [19:0] mk_exp(input bit b, input int o, input bit en, input bit rdy);
    logic [3:0] oh;
    logic [7:0] d;
    if (!b) return '0;
    oh = 4'b0001 << o;
    d  = en ? (8'hA0 + 8'(8'h11 * o)) : 8'h00;
    return {1'b1, oh, 2'(o), en, d, (rdy ? oh : 4'b0000)};
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    tick();
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_lock_i  = '0;
    dp_ready_i  = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    rst_i       = 1'b1;
    req_valid_i = 4'b1111;
    tick();
    #1;
    e = '0;
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs(), e);
    end
    rst_i       = 1'b0;
    req_valid_i = '0;
  endtask

  task automatic test_round_robin();
    logic [19:0] e;
    do_reset();
    tick();
    req_valid_i = 4'b1111;
    dp_ready_i  = 1'b1;
    #1;
    e = '0;
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rr_idle0: got %h want %h", obs(), e);
    end
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        #1;
        e = mk_exp(1'b1, b % 4, 1'b1, 1'b1);
        vectors++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL rr_burst%0d_beat%0d: got %h want %h", b, k, obs(), e);
        end
      end
      tick();
      #1;
      e = '0;
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rr_gap%0d: got %h want %h", b, obs(), e);
      end
    end
  endtask

  task automatic test_lone_requester();
    logic [19:0] e;
    do_reset();
    tick();
    req_valid_i = 4'b0100;
    #1;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        #1;
        e = mk_exp(1'b1, 2, 1'b1, 1'b1);
        vectors++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL lone_burst%0d_beat%0d: got %h want %h", b, k, obs(), e);
        end
      end
      tick();
      #1;
      e = '0;
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lone_gap%0d: got %h want %h", b, obs(), e);
      end
    end
  endtask

  task automatic test_stall();
    // Per-cycle dp_ready and expected (busy, ready-out) for owner 1.
    bit rdy_seq [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    bit bsy_seq [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [19:0] e;
    do_reset();
    tick();
    req_valid_i = 4'b0010;
    #1;
    for (int c = 0; c < 8; c++) begin
      tick();
      dp_ready_i = rdy_seq[c];
      #1;
      e = mk_exp(bsy_seq[c], 1, 1'b1, rdy_seq[c]);
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL stall_cyc%0d: got %h want %h", c, obs(), e);
      end
    end
    dp_ready_i = 1'b1;
  endtask

  task automatic test_owner_gap();
    logic [19:0] e;
    do_reset();
    tick();
    req_valid_i = 4'b1001;
    #1;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      e = mk_exp(1'b1, 0, 1'b1, 1'b1);
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL gap_beat%0d: got %h want %h", k, obs(), e);
      end
    end
    tick();
    req_valid_i = 4'b1000;
    #1;
    e = mk_exp(1'b1, 0, 1'b0, 1'b1);
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL gap_drop: got %h want %h", obs(), e);
    end
    tick();
    #1;
    e = '0;
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL gap_idle: got %h want %h", obs(), e);
    end
    tick();
    #1;
    e = mk_exp(1'b1, 3, 1'b1, 1'b1);
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL gap_next3: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [19:0] e;
    do_reset();
    tick();
    req_valid_i = 4'b0001;
    #1;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      e = mk_exp(1'b1, 0, 1'b1, 1'b1);
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rstmid_beat%0d: got %h want %h", k, obs(), e);
      end
    end
    tick();
    rst_i = 1'b1;
    #1;
    e = '0;
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rstmid_async: got %h want %h", obs(), e);
    end
    tick();
    rst_i       = 1'b0;
    req_valid_i = 4'b1111;
    #1;
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rstmid_idle: got %h want %h", obs(), e);
    end
    tick();
    #1;
    e = mk_exp(1'b1, 0, 1'b1, 1'b1);
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rstmid_req0: got %h want %h", obs(), e);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    int order [3] = '{2, 3, 0};
    logic [19:0] e;
    do_reset();
    tick();
    req_valid_i = 4'b0010;
    req_lock_i  = 4'b0010;
    #1;
    for (int k = 0; k < 10; k++) begin
      tick();
      req_valid_i = 4'b0011;
      #1;
      e = mk_exp(1'b1, 1, 1'b1, 1'b1);
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock_beat%0d: got %h want %h", k, obs(), e);
      end
    end
    tick();
    req_lock_i  = 4'b0000;
    req_valid_i = 4'b1111;
    #1;
    e = mk_exp(1'b1, 1, 1'b1, 1'b1);
    vectors++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL lock_last: got %h want %h", obs(), e);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      #1;
      e = '0;
      vectors++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock_gap%0d: got %h want %h", b, obs(), e);
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        #1;
        e = mk_exp(1'b1, order[b], 1'b1, 1'b1);
        vectors++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL lock_rot%0d_beat%0d: got %h want %h", b, k, obs(), e);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_lone_requester();
    test_stall();
    test_owner_gap();
    test_reset_mid_burst();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
